// File: rtl/tangnano9k_pmod_top.sv
// tangnano9k_pmod_top: Tang Nano 9K PMOD demo top.
// Each UART byte received is echoed back and becomes the display value. The display value
// drives a scanned 8x8 LED matrix, one 7-segment digit and the six on-board LEDs.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   button_s2             push button, active-low; a press clears the display value
//   uart_rx / uart_tx     8N1 serial in / echo out, idle high
//   row, d, seven_seg     matrix row select (one-hot), column/segment data, digit select
//   led                   on-board LEDs, active-low, show disp[5:0]
//   lcd_rs/rw/e, lcd_db   LCD pins parked at 0
//   debug_out             {rx_valid, tx_busy, slot[2:0], rx_sync}
module tangnano9k_pmod_top #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned SCAN_DIV     = 2700
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_s2,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] row,
  output logic [7:0] d,
  output logic       seven_seg,
  output logic [5:0] led,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_db,
  output logic [5:0] debug_out
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned DivW    = $clog2(SCAN_DIV + 1);
  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Synchronisers
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic btn_meta_q, btn_sync_q, btn_sample_q, btn_sample_d;

  // Scan
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      slot_q, slot_d;
  logic            scan_tick, btn_press;

  // Receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  // Transmitter
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      tx_frame_q, tx_frame_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

  // Display value and registered outputs
  logic [7:0] disp_q, disp_d;
  logic       uart_tx_q, uart_tx_d;
  logic [7:0] row_q, row_d;
  logic [7:0] d_q, d_d;
  logic       seven_seg_q, seven_seg_d;
  logic [5:0] led_q, led_d;
  logic [5:0] debug_q, debug_d;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] sh);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[3'(i) - sh];  // 3-bit index wraps modulo 8
    end
    return r;
  endfunction

  // Scan divider, slot counter and button sampling
  always_comb begin
    scan_tick    = (div_q == DivW'(SCAN_DIV - 1));
    div_d        = scan_tick ? '0 : div_q + DivW'(1);
    slot_d       = slot_q;
    btn_sample_d = btn_sample_q;
    if (scan_tick) begin
      slot_d       = (slot_q == 4'd8) ? 4'd0 : slot_q + 4'd1;
      btn_sample_d = btn_sync_q;
    end
    // Sampling only at scan ticks filters out contact bounce
    btn_press = scan_tick && btn_sample_q && !btn_sync_q;
  end

  // Receiver next state
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntW'(HalfBit - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (rx_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_valid_d = rx_sync_q;  // framing error drops the byte silently
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Transmitter next state; frame is {stop, data, start} shifted out LSB first
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_frame_d = tx_frame_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    if (!tx_busy_q) begin
      if (rx_valid_q) begin
        tx_busy_d  = 1'b1;
        tx_frame_d = {1'b1, rx_shift_q, 1'b0};
        tx_bit_d   = '0;
        tx_cnt_d   = '0;
      end
    end else if (tx_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
      end else begin
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CntW'(1);
    end
    uart_tx_d = tx_busy_d ? tx_frame_d[0] : 1'b1;
  end

  // Display value and outputs, computed from next-state so they land together
  always_comb begin
    disp_d = disp_q;
    if (btn_press)  disp_d = 8'h00;
    if (rx_valid_q) disp_d = rx_shift_q;  // received byte wins over a press

    if (slot_d == 4'd8) begin
      row_d       = 8'h00;
      seven_seg_d = 1'b1;
      d_d         = seg7(disp_d[3:0]);
    end else begin
      row_d       = 8'h01 << slot_d[2:0];
      seven_seg_d = 1'b0;
      d_d         = rotl8(disp_d, slot_d[2:0]);
    end
    led_d   = ~disp_d[5:0];
    debug_d = {rx_valid_d, tx_busy_d, slot_d[2:0], rx_meta_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      btn_meta_q   <= 1'b1;
      btn_sync_q   <= 1'b1;
      btn_sample_q <= 1'b1;
      div_q        <= '0;
      slot_q       <= '0;
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_valid_q   <= 1'b0;
      tx_busy_q    <= 1'b0;
      tx_frame_q   <= '1;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
      disp_q       <= '0;
      uart_tx_q    <= 1'b1;
      row_q        <= 8'h01;
      d_q          <= 8'h00;
      seven_seg_q  <= 1'b0;
      led_q        <= 6'h3F;
      debug_q      <= 6'b000001;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      btn_meta_q   <= button_s2;
      btn_sync_q   <= btn_meta_q;
      btn_sample_q <= btn_sample_d;
      div_q        <= div_d;
      slot_q       <= slot_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_valid_q   <= rx_valid_d;
      tx_busy_q    <= tx_busy_d;
      tx_frame_q   <= tx_frame_d;
      tx_bit_q     <= tx_bit_d;
      tx_cnt_q     <= tx_cnt_d;
      disp_q       <= disp_d;
      uart_tx_q    <= uart_tx_d;
      row_q        <= row_d;
      d_q          <= d_d;
      seven_seg_q  <= seven_seg_d;
      led_q        <= led_d;
      debug_q      <= debug_d;
    end
  end

  assign uart_tx   = uart_tx_q;
  assign row       = row_q;
  assign d         = d_q;
  assign seven_seg = seven_seg_q;
  assign led       = led_q;
  assign debug_out = debug_q;
  assign lcd_rs    = 1'b0;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = 1'b0;
  assign lcd_db    = 4'h0;

endmodule

// File: tb/tb_tangnano9k_pmod_top.sv
// Directed bench: one instance at board rates for the idle/scan-timing run, one at
// CLKS_PER_BIT=8 / SCAN_DIV=4 for the UART, scan and button behaviour.
module tb_tangnano9k_pmod_top;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Board-rate instance
  logic       b_btn = 1'b1, b_rx = 1'b1;
  logic       b_tx, b_seven, b_lcd_rs, b_lcd_rw, b_lcd_e;
  logic [7:0] b_row, b_d;
  logic [5:0] b_led, b_dbg;
  logic [3:0] b_lcd_db;

  // Fast instance
  logic       s_btn = 1'b1, s_rx = 1'b1;
  logic       s_tx, s_seven, s_lcd_rs, s_lcd_rw, s_lcd_e;
  logic [7:0] s_row, s_d;
  logic [5:0] s_led, s_dbg;
  logic [3:0] s_lcd_db;

  tangnano9k_pmod_top #(.CLKS_PER_BIT(234), .SCAN_DIV(2700)) u_big (
    .clock(clock), .reset(reset), .button_s2(b_btn), .uart_rx(b_rx), .uart_tx(b_tx),
    .row(b_row), .d(b_d), .seven_seg(b_seven), .led(b_led), .lcd_rs(b_lcd_rs),
    .lcd_rw(b_lcd_rw), .lcd_e(b_lcd_e), .lcd_db(b_lcd_db), .debug_out(b_dbg)
  );

  tangnano9k_pmod_top #(.CLKS_PER_BIT(8), .SCAN_DIV(4)) u_dut (
    .clock(clock), .reset(reset), .button_s2(s_btn), .uart_rx(s_rx), .uart_tx(s_tx),
    .row(s_row), .d(s_d), .seven_seg(s_seven), .led(s_led), .lcd_rs(s_lcd_rs),
    .lcd_rw(s_lcd_rw), .lcd_e(s_lcd_e), .lcd_db(s_lcd_db), .debug_out(s_dbg)
  );

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  logic [7:0] echo_q[$];
  logic       echo_stop_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count rx_valid pulses as seen on the debug bus
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset && s_dbg[5]) rxv_cnt++;
  end

  // Decode echoed frames at mid-bit
  initial forever begin
    logic [7:0] b;
    @(negedge clock);
    if (!reset && s_tx == 1'b0) begin
      repeat (4) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (8) @(negedge clock);
        b[i] = s_tx;
      end
      repeat (8) @(negedge clock);
      echo_q.push_back(b);
      echo_stop_q.push_back(s_tx);
    end
  end

  task automatic send_byte(input logic [7:0] data, input logic stop, input int stop_len);
    @(negedge clock);
    s_rx = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      s_rx = data[i];
      repeat (8) @(negedge clock);
    end
    s_rx = stop;
    repeat (stop_len) @(negedge clock);
    s_rx = 1'b1;
  endtask

  task automatic wait_rxv(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clock);
      #1;
      if (s_dbg[5]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_echo(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clock);
      if (echo_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_row(input logic [7:0] r, input logic seven, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (s_row == r && s_seven == seven) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    int   n_rxv, n_echo;
    logic [7:0] scan_d[9];
    scan_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};

    repeat (3) @(negedge clock);
    #1;
    check("reset_row", s_row, 8'h01);
    check("reset_d", s_d, 8'h00);
    check("reset_seven", s_seven, 1'b0);
    check("reset_led", s_led, 6'h3F);
    check("reset_tx", s_tx, 1'b1);
    check("reset_lcd", {s_lcd_rs, s_lcd_rw, s_lcd_e, s_lcd_db}, 7'h00);
    check("reset_debug", s_dbg, 6'b000001);
    @(negedge clock);
    reset = 1'b0;

    fork
      begin : big_idle
        int bad_tx, bad_led, bad_d, bad_row;
        bad_tx = 0; bad_led = 0; bad_d = 0; bad_row = 0;
        for (int k = 0; k < 10000; k++) begin
          if (b_tx !== 1'b1) bad_tx++;
          if (b_led !== 6'h3F) bad_led++;
          if (b_d !== 8'h00) bad_d++;
          if (b_row !== (8'h01 << (k / 2700))) bad_row++;
          @(posedge clock);
          #1;
        end
        check("idle_tx_bad_cycles", bad_tx, 0);
        check("idle_led_bad_cycles", bad_led, 0);
        check("idle_d_bad_cycles", bad_d, 0);
        check("idle_row_step_bad_cycles", bad_row, 0);
      end
      begin : scan_run
        for (int k = 0; k < 41; k++) begin
          int s;
          s = (k / 4) % 9;
          check($sformatf("scan_row_k%0d", k), s_row, (s == 8) ? 8'h00 : (8'h01 << s));
          check($sformatf("scan_seven_k%0d", k), s_seven, (s == 8));
          check($sformatf("scan_d_k%0d", k), s_d, scan_d[s]);
          @(posedge clock);
          #1;
        end
      end
    join

    // Receive 0x55, check update timing and echo
    fork
      send_byte(8'h55, 1'b1, 8);
      begin
        wait_rxv(200, ok);
        check("rxv_55_seen", ok, 1'b1);
        check("tx_idle_at_rxv", s_tx, 1'b1);
        check("led_before_update", s_led, 6'h3F);
        @(posedge clock);
        #1;
        check("echo_start_bit", s_tx, 1'b0);
        check("led_55", s_led, 6'h2A);
      end
    join
    wait_echo(1, 200, ok);
    check("echo_55_done", ok, 1'b1);
    if (ok) begin
      check("echo_55_byte", echo_q[0], 8'h55);
      check("echo_55_stop", echo_stop_q[0], 1'b1);
    end
    wait_row(8'h02, 1'b0, ok);
    check("slot1_found", ok, 1'b1);
    check("slot1_d", s_d, 8'hAA);
    check("slot1_debug", s_dbg[3:1], 3'd1);
    wait_row(8'h00, 1'b1, ok);
    check("slot8_found", ok, 1'b1);
    check("slot8_d", s_d, 8'h6D);
    check("slot8_debug", s_dbg[3:1], 3'd0);

    // Framing error: no pulse, no echo, display unchanged
    n_rxv = rxv_cnt;
    n_echo = echo_q.size();
    send_byte(8'hA3, 1'b0, 8);
    repeat (150) @(posedge clock);
    #1;
    check("ferr_no_rxv", rxv_cnt, n_rxv);
    check("ferr_no_echo", echo_q.size(), n_echo);
    check("ferr_led_kept", s_led, 6'h2A);
    check("ferr_tx_idle", s_tx, 1'b1);

    // Button press across scan ticks clears the display
    @(negedge clock);
    s_btn = 1'b0;
    repeat (16) @(negedge clock);
    s_btn = 1'b1;
    repeat (4) @(negedge clock);
    check("btn_led_cleared", s_led, 6'h3F);

    // Second byte starts while the first is still being echoed
    n_rxv = rxv_cnt;
    n_echo = echo_q.size();
    send_byte(8'h3C, 1'b1, 6);
    send_byte(8'hC6, 1'b1, 8);
    repeat (250) @(posedge clock);
    #1;
    check("b2b_rxv_pulses", rxv_cnt - n_rxv, 2);
    check("b2b_echo_count", echo_q.size() - n_echo, 1);
    if (echo_q.size() > n_echo) check("b2b_echo_byte", echo_q[n_echo], 8'h3C);
    check("b2b_led_byte2", s_led, 6'h39);

    // Reset in the middle of an echo
    fork
      send_byte(8'hF0, 1'b1, 8);
      begin
        wait_rxv(200, ok);
        check("rxv_f0_seen", ok, 1'b1);
      end
    join
    repeat (18) @(posedge clock);
    #3;
    check("midframe_tx_low", s_tx, 1'b0);
    check("midframe_led", s_led, 6'h0F);
    reset = 1'b1;
    #1;
    check("abort_tx_high", s_tx, 1'b1);
    check("abort_led", s_led, 6'h3F);
    check("abort_row", s_row, 8'h01);
    check("abort_debug", s_dbg, 6'b000001);
    repeat (5) @(posedge clock);
    #1;
    check("held_reset_row", s_row, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
